// File: rtl/xif_mem_responder.sv
// xif_mem_responder: serves memory requests offloaded by a coprocessor,
// optionally waits for the core to commit speculative requests, performs a
// single OBI transaction and returns a one-cycle result pulse.
// One transaction is outstanding at a time.
// Optional feature: define XIF_MEM_ALIGN_CHECK_EN to make misaligned
// requests skip the bus and return err=1.
module xif_mem_responder #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_MEM_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // coprocessor memory request
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  logic [X_ID_WIDTH-1:0]  mem_id_i,
  input  logic [31:0]            mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [2:0]             mem_size_i,
  input  logic [3:0]             mem_be_i,
  input  logic [X_MEM_WIDTH-1:0] mem_wdata_i,
  input  logic                   mem_spec_i,
  // core commit channel
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  // result channel (no back-pressure)
  output logic                   mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0]  mem_result_id_o,
  output logic [X_MEM_WIDTH-1:0] mem_result_rdata_o,
  output logic                   mem_result_err_o,
  output logic                   mem_result_dbg_o,
  // OBI address phase
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [31:0]            obi_addr_o,
  output logic                   obi_we_o,
  output logic [3:0]             obi_be_o,
  output logic [X_MEM_WIDTH-1:0] obi_wdata_o,
  // OBI response phase
  input  logic                   obi_rvalid_i,
  input  logic [X_MEM_WIDTH-1:0] obi_rdata_i,
  input  logic                   obi_err_i
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_COMMIT = 3'd1,
    ST_BUS_REQ     = 3'd2,
    ST_BUS_RESP    = 3'd3,
    ST_RESULT      = 3'd4
  } state_e;

  state_e                 state_r, state_nx_s;

  // stored request payload and captured response
  logic [X_ID_WIDTH-1:0]  id_r,    id_nx_s;
  logic [31:0]            addr_r,  addr_nx_s;
  logic                   we_r,    we_nx_s;
  logic [2:0]             size_r,  size_nx_s;
  logic [3:0]             be_r,    be_nx_s;
  logic [X_MEM_WIDTH-1:0] wdata_r, wdata_nx_s;
  logic [X_MEM_WIDTH-1:0] rdata_r, rdata_nx_s;
  logic                   err_r,   err_nx_s;

  // registered outputs
  logic                   mem_ready_r;
  logic                   res_valid_r;
  logic [X_ID_WIDTH-1:0]  res_id_r;
  logic [X_MEM_WIDTH-1:0] res_rdata_r;
  logic                   res_err_r;
  logic                   obi_req_r;
  logic [31:0]            obi_addr_r;
  logic                   obi_we_r;
  logic [3:0]             obi_be_r;
  logic [X_MEM_WIDTH-1:0] obi_wdata_r;

  // misalignment of the incoming request and of the stored request
  logic                   misal_in_s;
  logic                   misal_st_s;

`ifdef XIF_MEM_ALIGN_CHECK_EN
  function automatic logic misaligned_f(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic m;
    case (size)
      3'd1:    m = addr_lsb[0];
      3'd2:    m = (addr_lsb != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  assign misal_in_s = misaligned_f(mem_size_i, mem_addr_i[1:0]);
  assign misal_st_s = misaligned_f(size_r, addr_r[1:0]);
`else
  assign misal_in_s = 1'b0;
  assign misal_st_s = 1'b0;
  // size is stored with the payload but only consulted by the alignment check
  logic unused_size_s;
  assign unused_size_s = ^size_r;
`endif

  // next-state and next-payload decode for the request/commit/bus sequence
  always_comb begin
    state_nx_s = state_r;
    id_nx_s    = id_r;
    addr_nx_s  = addr_r;
    we_nx_s    = we_r;
    size_nx_s  = size_r;
    be_nx_s    = be_r;
    wdata_nx_s = wdata_r;
    rdata_nx_s = rdata_r;
    err_nx_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid_i) begin
          id_nx_s    = mem_id_i;
          addr_nx_s  = mem_addr_i;
          we_nx_s    = mem_we_i;
          size_nx_s  = mem_size_i;
          be_nx_s    = mem_be_i;
          wdata_nx_s = mem_wdata_i;
          rdata_nx_s = {X_MEM_WIDTH{1'b0}};
          // a misaligned request reaches RESULT with err already set
          err_nx_s   = misal_in_s;
          if (!mem_spec_i) begin
            state_nx_s = misal_in_s ? ST_RESULT : ST_BUS_REQ;
          end else if (commit_valid_i && (commit_id_i == mem_id_i)) begin
            // commit arriving together with the request is honoured directly
            if (commit_kill_i) begin
              state_nx_s = ST_IDLE;
            end else begin
              state_nx_s = misal_in_s ? ST_RESULT : ST_BUS_REQ;
            end
          end else begin
            state_nx_s = ST_WAIT_COMMIT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT_COMMIT: begin
        if (commit_valid_i && (commit_id_i == id_r)) begin
          if (commit_kill_i) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = misal_st_s ? ST_RESULT : ST_BUS_REQ;
          end
        end else begin
          state_nx_s = ST_WAIT_COMMIT;
        end
      end
      ST_BUS_REQ: begin
        if (obi_gnt_i) begin
          state_nx_s = ST_BUS_RESP;
        end else begin
          state_nx_s = ST_BUS_REQ;
        end
      end
      ST_BUS_RESP: begin
        // commit kills are no longer relevant once the bus is issued
        if (obi_rvalid_i) begin
          rdata_nx_s = we_r ? {X_MEM_WIDTH{1'b0}} : obi_rdata_i;
          err_nx_s   = obi_err_i;
          state_nx_s = ST_RESULT;
        end else begin
          state_nx_s = ST_BUS_RESP;
        end
      end
      ST_RESULT: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // state, payload and output registers; outputs are derived from next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      id_r        <= {X_ID_WIDTH{1'b0}};
      addr_r      <= 32'd0;
      we_r        <= 1'b0;
      size_r      <= 3'd0;
      be_r        <= 4'd0;
      wdata_r     <= {X_MEM_WIDTH{1'b0}};
      rdata_r     <= {X_MEM_WIDTH{1'b0}};
      err_r       <= 1'b0;
      mem_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_id_r    <= {X_ID_WIDTH{1'b0}};
      res_rdata_r <= {X_MEM_WIDTH{1'b0}};
      res_err_r   <= 1'b0;
      obi_req_r   <= 1'b0;
      obi_addr_r  <= 32'd0;
      obi_we_r    <= 1'b0;
      obi_be_r    <= 4'd0;
      obi_wdata_r <= {X_MEM_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      id_r        <= id_nx_s;
      addr_r      <= addr_nx_s;
      we_r        <= we_nx_s;
      size_r      <= size_nx_s;
      be_r        <= be_nx_s;
      wdata_r     <= wdata_nx_s;
      rdata_r     <= rdata_nx_s;
      err_r       <= err_nx_s;
      mem_ready_r <= (state_nx_s == ST_IDLE);
      res_valid_r <= (state_nx_s == ST_RESULT);
      res_id_r    <= (state_nx_s == ST_RESULT) ? id_nx_s : {X_ID_WIDTH{1'b0}};
      res_rdata_r <= (state_nx_s == ST_RESULT) ? rdata_nx_s : {X_MEM_WIDTH{1'b0}};
      res_err_r   <= (state_nx_s == ST_RESULT) ? err_nx_s : 1'b0;
      obi_req_r   <= (state_nx_s == ST_BUS_REQ);
      obi_addr_r  <= (state_nx_s == ST_BUS_REQ) ? addr_nx_s : 32'd0;
      obi_we_r    <= (state_nx_s == ST_BUS_REQ) ? we_nx_s : 1'b0;
      obi_be_r    <= (state_nx_s == ST_BUS_REQ) ? be_nx_s : 4'd0;
      obi_wdata_r <= (state_nx_s == ST_BUS_REQ) ? wdata_nx_s : {X_MEM_WIDTH{1'b0}};
    end
  end

  assign mem_ready_o        = mem_ready_r;
  assign mem_result_valid_o = res_valid_r;
  assign mem_result_id_o    = res_id_r;
  assign mem_result_rdata_o = res_rdata_r;
  assign mem_result_err_o   = res_err_r;
  assign mem_result_dbg_o   = 1'b0;
  assign obi_req_o          = obi_req_r;
  assign obi_addr_o         = obi_addr_r;
  assign obi_we_o           = obi_we_r;
  assign obi_be_o           = obi_be_r;
  assign obi_wdata_o        = obi_wdata_r;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder: expected results are queued when a
// request is driven and compared when the result pulse appears.
module tb_xif_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [3:0]  mem_id_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [2:0]  mem_size_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i;
  logic        mem_spec_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        mem_result_valid_o;
  logic [3:0]  mem_result_id_o;
  logic [31:0] mem_result_rdata_o;
  logic        mem_result_err_o;
  logic        mem_result_dbg_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  xif_mem_responder #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_id_i(mem_id_i),
    .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i), .mem_spec_i(mem_spec_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .mem_result_valid_o(mem_result_valid_o), .mem_result_id_o(mem_result_id_o),
    .mem_result_rdata_o(mem_result_rdata_o), .mem_result_err_o(mem_result_err_o),
    .mem_result_dbg_o(mem_result_dbg_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_res  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [2:0] size, input logic [31:0] wdata, input logic spec);
    mem_valid_i = 1'b1; mem_id_i = id; mem_addr_i = addr; mem_we_i = we;
    mem_size_i = size; mem_be_i = 4'hF; mem_wdata_i = wdata; mem_spec_i = spec;
  endtask

  task automatic idle_inputs();
    mem_valid_i = 1'b0; mem_id_i = 4'd0; mem_addr_i = 32'd0; mem_we_i = 1'b0;
    mem_size_i = 3'd0; mem_be_i = 4'd0; mem_wdata_i = 32'd0; mem_spec_i = 1'b0;
    commit_valid_i = 1'b0; commit_id_i = 4'd0; commit_kill_i = 1'b0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'd0; obi_err_i = 1'b0;
  endtask

  // result monitor: every pulse must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (mem_result_valid_o === 1'b1) begin
      n_res++;
      chk("result_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_id", {28'd0, mem_result_id_o}, {28'd0, e.id});
        chk("result_rdata", mem_result_rdata_o, e.rdata);
        chk("result_err", {31'd0, mem_result_err_o}, {31'd0, e.err});
        chk("result_dbg", {31'd0, mem_result_dbg_o}, 32'd0);
      end
    end
  end

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    // reset state
    step(); step();
    chk("rst_ready", {31'd0, mem_ready_o}, 32'd1);
    chk("rst_obi_req", {31'd0, obi_req_o}, 32'd0);
    chk("rst_res_valid", {31'd0, mem_result_valid_o}, 32'd0);
    chk("rst_obi_addr", obi_addr_o, 32'd0);
    rst_i = 1'b0;
    step();

    // non-spec read, immediate gnt/rvalid: result at cycle 3
    drive_req(4'd3, 32'h100, 1'b0, 3'd2, 32'd0, 1'b0);
    push_exp(4'd3, 32'hCAFEF00D, 1'b0);
    step();                                   // cycle 1
    idle_inputs();
    chk("lat_req_c1", {31'd0, obi_req_o}, 32'd1);
    chk("lat_addr_c1", obi_addr_o, 32'h100);
    chk("lat_ready_c1", {31'd0, mem_ready_o}, 32'd0);
    obi_gnt_i = 1'b1;
    step();                                   // cycle 2
    obi_gnt_i = 1'b0;
    chk("lat_req_c2", {31'd0, obi_req_o}, 32'd0);
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hCAFEF00D;
    step();                                   // cycle 3
    idle_inputs();
    chk("lat_valid_c3", {31'd0, mem_result_valid_o}, 32'd1);
    chk("lat_ready_c3", {31'd0, mem_ready_o}, 32'd0);
    step();
    chk("lat_valid_c4", {31'd0, mem_result_valid_o}, 32'd0);
    chk("lat_ready_c4", {31'd0, mem_ready_o}, 32'd1);

    // speculative write, committed two cycles later
    drive_req(4'd5, 32'h200, 1'b1, 3'd2, 32'h12345678, 1'b1);
    push_exp(4'd5, 32'd0, 1'b0);
    step();
    idle_inputs();
    chk("sw_wait_req", {31'd0, obi_req_o}, 32'd0);
    step();
    commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b0;
    step();
    idle_inputs();
    chk("sw_req", {31'd0, obi_req_o}, 32'd1);
    chk("sw_addr", obi_addr_o, 32'h200);
    chk("sw_we", {31'd0, obi_we_o}, 32'd1);
    chk("sw_be", {28'd0, obi_be_o}, 32'hF);
    chk("sw_wdata", obi_wdata_o, 32'h12345678);
    obi_gnt_i = 1'b1;
    step();
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEADBEEF;   // write result data reads 0
    step();
    idle_inputs();
    step();

    // speculative read killed after an ignored non-matching commit
    drive_req(4'd7, 32'h300, 1'b0, 3'd2, 32'd0, 1'b1);
    step();
    idle_inputs();
    commit_valid_i = 1'b1; commit_id_i = 4'd2; commit_kill_i = 1'b1;
    step();
    chk("kill_wait_ready", {31'd0, mem_ready_o}, 32'd0);
    commit_id_i = 4'd7;
    step();
    idle_inputs();
    chk("kill_req", {31'd0, obi_req_o}, 32'd0);
    chk("kill_ready", {31'd0, mem_ready_o}, 32'd1);

    // commit in the acceptance cycle, kill=0, plus stray rvalid in IDLE
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11111111;
    drive_req(4'd9, 32'h340, 1'b0, 3'd2, 32'd0, 1'b1);
    commit_valid_i = 1'b1; commit_id_i = 4'd9; commit_kill_i = 1'b0;
    push_exp(4'd9, 32'hA5A5A5A5, 1'b0);
    step();
    idle_inputs();
    chk("samecyc_req", {31'd0, obi_req_o}, 32'd1);
    obi_gnt_i = 1'b1;
    step();
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hA5A5A5A5;
    step();
    idle_inputs();
    step();

    // commit with kill in the acceptance cycle
    drive_req(4'd10, 32'h380, 1'b0, 3'd2, 32'd0, 1'b1);
    commit_valid_i = 1'b1; commit_id_i = 4'd10; commit_kill_i = 1'b1;
    step();
    idle_inputs();
    chk("samecyc_kill_req", {31'd0, obi_req_o}, 32'd0);
    chk("samecyc_kill_ready", {31'd0, mem_ready_o}, 32'd1);

    // grant delayed 4 cycles, early rvalid ignored, bus error returned
    drive_req(4'd2, 32'h3C0, 1'b0, 3'd2, 32'd0, 1'b0);
    push_exp(4'd2, 32'h55AA55AA, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk("dly_req", {31'd0, obi_req_o}, 32'd1);
      chk("dly_addr", obi_addr_o, 32'h3C0);
      obi_rvalid_i = (i == 0); obi_rdata_i = 32'h99999999;
      obi_gnt_i = (i == 3);
      step();
    end
    obi_gnt_i = 1'b0;
    chk("dly_req_after_gnt", {31'd0, obi_req_o}, 32'd0);
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h55AA55AA; obi_err_i = 1'b1;
    step();
    idle_inputs();
    step();

    // misaligned word access at 0x102
    drive_req(4'd4, 32'h102, 1'b0, 3'd2, 32'd0, 1'b0);
`ifdef XIF_MEM_ALIGN_CHECK_EN
    push_exp(4'd4, 32'd0, 1'b1);
    step();
    idle_inputs();
    chk("misal_req", {31'd0, obi_req_o}, 32'd0);
    chk("misal_valid", {31'd0, mem_result_valid_o}, 32'd1);
    step();
`else
    push_exp(4'd4, 32'h0BADF00D, 1'b0);
    step();
    idle_inputs();
    chk("misal_req", {31'd0, obi_req_o}, 32'd1);
    chk("misal_addr", obi_addr_o, 32'h102);
    obi_gnt_i = 1'b1;
    step();
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h0BADF00D;
    step();
    idle_inputs();
    step();
`endif

    // reset while in BUS_RESP; late rvalid must not produce a result
    drive_req(4'd6, 32'h400, 1'b0, 3'd2, 32'd0, 1'b0);
    step();
    idle_inputs();
    chk("rstmid_req", {31'd0, obi_req_o}, 32'd1);
    obi_gnt_i = 1'b1;
    step();
    obi_gnt_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rstmid_req_after", {31'd0, obi_req_o}, 32'd0);
    chk("rstmid_ready_after", {31'd0, mem_ready_o}, 32'd1);
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h77777777;
    step();
    idle_inputs();
    chk("rstmid_no_result", {31'd0, mem_result_valid_o}, 32'd0);

    // drain and confirm every expected result was seen exactly once
    for (int i = 0; i < 4; i++) step();
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("result_count", n_res, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the offloaded-instruction ID.
REQ-002 Parameter X_MEM_WIDTH, default 32, data width; only 32 is supported.
REQ-003 The block SHALL use one clock and a synchronous active-high reset; ports clk_i (in, 1, clock) and rst_i (in, 1, reset).
REQ-004 mem_valid_i / mem_ready_o, in/out, 1 each: coprocessor memory request handshake.
REQ-005 mem_id_i (in, X_ID_WIDTH), mem_addr_i (in, 32), mem_we_i (in, 1), mem_size_i (in, 3), mem_be_i (in, 4), mem_wdata_i (in, 32), mem_spec_i (in, 1): request payload.
REQ-006 commit_valid_i (in, 1), commit_id_i (in, X_ID_WIDTH), commit_kill_i (in, 1): core commit channel.
REQ-007 mem_result_valid_o (out, 1), mem_result_id_o (out, X_ID_WIDTH), mem_result_rdata_o (out, 32), mem_result_err_o (out, 1), mem_result_dbg_o (out, 1): result channel; it has no ready signal.
REQ-008 obi_req_o (out, 1), obi_gnt_i (in, 1), obi_addr_o (out, 32), obi_we_o (out, 1), obi_be_o (out, 4), obi_wdata_o (out, 32): OBI address phase.
REQ-009 obi_rvalid_i (in, 1), obi_rdata_i (in, 32), obi_err_i (in, 1): OBI response phase.

Function
REQ-010 The block SHALL implement FSM states IDLE, WAIT_COMMIT, BUS_REQ, BUS_RESP, RESULT.
REQ-011 mem_ready_o SHALL be 1 only in IDLE; a request is accepted when mem_valid_i & mem_ready_o, and its payload is registered.
REQ-012 On acceptance: mem_spec_i=0 -> BUS_REQ; mem_spec_i=1 -> WAIT_COMMIT.
REQ-013 In WAIT_COMMIT, commit_valid_i with commit_id_i == stored ID SHALL select the next state: kill=0 -> BUS_REQ; kill=1 -> IDLE with no bus access and no result; a non-matching ID is ignored.
REQ-014 A matching commit in the acceptance cycle SHALL be honoured exactly as if it arrived in WAIT_COMMIT.
REQ-015 BUS_REQ: obi_req_o=1 and the address-phase outputs are driven from the stored payload, held stable until obi_gnt_i; grant -> BUS_RESP.
REQ-016 BUS_RESP: wait for obi_rvalid_i, capture obi_rdata_i and obi_err_i -> RESULT; commit_kill_i SHALL be ignored once the bus is issued.
REQ-017 RESULT: mem_result_valid_o SHALL be a one-cycle pulse carrying the stored ID, captured rdata (0 for writes), err, dbg=0; then IDLE.
REQ-018 Latency, non-spec read with gnt and rvalid in the first possible cycles: accept at cycle 0, obi_req_o at cycle 1, rvalid at cycle 2, mem_result_valid_o at cycle 3.
REQ-019 At most one transaction outstanding; back-to-back requests accepted no earlier than the cycle after the RESULT pulse.
REQ-020 obi_rvalid_i outside BUS_RESP SHALL be ignored.

Reset
REQ-021 Reset SHALL force IDLE; mem_ready_o=1 during IDLE; all other outputs 0; stored payload 0.
REQ-022 Reset mid-transaction SHALL drop obi_req_o the next cycle; no result is produced for the aborted request.

Configuration
REQ-023 Macro XIF_MEM_ALIGN_CHECK_EN defined: a request whose address is misaligned for its size (size 1: addr[0]!=0; size 2: addr[1:0]!=0) SHALL skip the bus and go straight to RESULT with err=1, rdata=0, after spec/commit handling.
REQ-024 Macro undefined: no alignment check; all requests are forwarded to OBI unchanged.

Verification
REQ-025 Non-spec read addr 0x100, id 3, memory holding 0xCAFEF00D, gnt/rvalid immediate -> result at cycle 3, id 3, rdata 0xCAFEF00D, err 0.
REQ-026 Spec write addr 0x200, wdata 0x12345678, id 5; commit id 5 kill=0 two cycles later -> OBI write with be 0xF; result id 5, err 0.
REQ-027 Spec read id 7; commit id 2 (ignored), then commit id 7 kill=1 -> no obi_req_o, no result, mem_ready_o=1 the next cycle.
REQ-028 Read with gnt delayed 4 cycles and obi_err_i=1 -> address stable throughout; result err 1.
REQ-029 With XIF_MEM_ALIGN_CHECK_EN: size 2, addr 0x102 -> no obi_req_o, result err 1; without the macro -> OBI access to 0x102.
REQ-030 rst_i asserted while in BUS_RESP -> obi_req_o=0 and mem_ready_o=1 after reset; a late rvalid produces no result.
